setup_loader: RTL and testbench

Sequencer that loads a parallel configuration word into the serial `Setup_reg` of the floating-point adder. It accepts a word over a valid/ready handshake, drives `Setup_reg`'s `serial_in`/`en_in` LSB-first for exactly WIDTH cycles, then waits and compares `Setup_reg`'s `parallel_out` against the word it sent. It sits between the host/config interface and `Setup_reg`, and is the only driver of that register's enable.

---
 rtl/setup_loader.sv | 136 +++++++++++++
 tb/tb_setup_loader.sv | 184 ++++++++++++++++++
 2 files changed

// File: rtl/setup_loader.sv
// setup_loader: loads a parallel configuration word into the serial Setup_reg
// LSB-first, waits for the register to settle, then verifies its parallel
// readback against the word that was sent.
module setup_loader #(
    parameter int WIDTH  = 8,
    parameter int SETTLE = 1
) (
    input  logic             clk_in,
    input  logic             rst_in,
    input  logic [WIDTH-1:0] cfg_data_in,
    input  logic             cfg_valid_in,
    output logic             cfg_ready_out,
    output logic             serial_out,
    output logic             shift_en_out,
    input  logic [WIDTH-1:0] readback_in,
    output logic             busy_out,
    output logic             done_out,
    output logic             err_out,
    output logic             cfg_ok_out
);

    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam int SW = (SETTLE > 1) ? $clog2(SETTLE) : 1;
    localparam logic [CW-1:0] LAST_BIT    = CW'(WIDTH - 1);
    localparam logic [CW-1:0] BIT_ONE     = CW'(1);
    localparam logic [SW-1:0] SETTLE_INIT = SW'(SETTLE - 1);
    localparam logic [SW-1:0] SETTLE_ONE  = SW'(1);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_SHIFT  = 2'd1,
        S_SETTLE = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] word_q, word_d;
    logic [CW-1:0]    bit_cnt_q, bit_cnt_d;
    logic [SW-1:0]    settle_q, settle_d;
    logic             serial_d, shift_en_d, done_d, err_d, cfg_ok_d;

    logic             accept;
    logic             last_shift;
    logic             settle_end;
    logic [CW-1:0]    bit_next;

    assign accept     = (state_q == S_IDLE) && cfg_valid_in;
    assign last_shift = (state_q == S_SHIFT) && (bit_cnt_q == LAST_BIT);
    assign settle_end = (state_q == S_SETTLE) && (settle_q == '0);
    assign bit_next   = bit_cnt_q + BIT_ONE;

    // Ready and busy are pure decodes of the state register.
    assign cfg_ready_out = (state_q == S_IDLE);
    assign busy_out      = (state_q != S_IDLE);

    // State and registered outputs; reset wins over a same-edge request.
    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            state_q      <= S_IDLE;
            word_q       <= '0;
            bit_cnt_q    <= '0;
            settle_q     <= '0;
            serial_out   <= 1'b0;
            shift_en_out <= 1'b0;
            done_out     <= 1'b0;
            err_out      <= 1'b0;
            cfg_ok_out   <= 1'b0;
        end else begin
            state_q      <= state_d;
            word_q       <= word_d;
            bit_cnt_q    <= bit_cnt_d;
            settle_q     <= settle_d;
            serial_out   <= serial_d;
            shift_en_out <= shift_en_d;
            done_out     <= done_d;
            err_out      <= err_d;
            cfg_ok_out   <= cfg_ok_d;
        end
    end

    // Next-state: IDLE -> SHIFT on accept, SHIFT -> SETTLE after the last bit,
    // SETTLE -> IDLE once the settle count expires.
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:   if (accept)     state_d = S_SHIFT;
            S_SHIFT:  if (last_shift) state_d = S_SETTLE;
            S_SETTLE: if (settle_end) state_d = S_IDLE;
            default:                  state_d = S_IDLE;
        endcase
    end

    // Next values of the datapath and registered outputs. The first bit goes
    // out at the accept edge, so the enable covers exactly WIDTH cycles.
    always_comb begin
        word_d     = word_q;
        bit_cnt_d  = bit_cnt_q;
        settle_d   = settle_q;
        serial_d   = 1'b0;
        shift_en_d = 1'b0;
        done_d     = 1'b0;
        err_d      = err_out;
        cfg_ok_d   = cfg_ok_out;
        case (state_q)
            S_IDLE: begin
                if (accept) begin
                    word_d     = cfg_data_in;
                    bit_cnt_d  = '0;
                    err_d      = 1'b0;
                    cfg_ok_d   = 1'b0;
                    shift_en_d = 1'b1;
                    serial_d   = cfg_data_in[0];
                end
            end
            S_SHIFT: begin
                if (last_shift) begin
                    settle_d = SETTLE_INIT;
                end else begin
                    bit_cnt_d  = bit_next;
                    shift_en_d = 1'b1;
                    serial_d   = word_q[bit_next];
                end
            end
            S_SETTLE: begin
                if (settle_end) begin
                    done_d   = 1'b1;
                    err_d    = (readback_in != word_q);
                    cfg_ok_d = (readback_in == word_q);
                end else begin
                    settle_d = settle_q - SETTLE_ONE;
                end
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_setup_loader.sv
// Scoreboard bench for setup_loader with a behavioural Setup_reg attached.
module tb_setup_loader;

    localparam int W = 8;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic [W-1:0] cfg_data = 8'h5A;
    logic         cfg_valid = 1'b1;
    logic         cfg_ready, serial, shift_en, busy, done, err, cfg_ok;
    logic [W-1:0] readback;
    logic [W-1:0] sr = '0;
    logic         rb_force = 1'b0;
    int           cyc = 0;

    int checks = 0;
    int failures = 0;

    typedef struct {
        logic [W-1:0] w;
        logic         err;
        logic         ok;
        int           acc;
    } exp_t;
    exp_t q[$];

    setup_loader #(.WIDTH(W), .SETTLE(1)) dut (
        .clk_in(clk), .rst_in(rst), .cfg_data_in(cfg_data), .cfg_valid_in(cfg_valid),
        .cfg_ready_out(cfg_ready), .serial_out(serial), .shift_en_out(shift_en),
        .readback_in(readback), .busy_out(busy), .done_out(done), .err_out(err),
        .cfg_ok_out(cfg_ok)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Setup_reg model: shifts in at the MSB so the first bit ends at bit 0.
    always @(posedge clk) if (shift_en) sr <= {serial, sr[W-1:1]};
    assign readback = rb_force ? 8'h34 : sr;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Monitor: records shifted bits and pops the scoreboard on each done pulse.
    logic [W-1:0] bits;
    int           nsh = 0;
    logic         prev_en = 1'b0;
    always @(negedge clk) begin
        if (shift_en) begin
            if (!prev_en) nsh = 0;
            if (nsh < W) bits[nsh] = serial;
            nsh++;
        end
        prev_en = shift_en;
        if (done) begin
            if (q.size() == 0) begin
                chk("unexpected_done", 1, 0);
            end else begin
                exp_t e;
                e = q.pop_front();
                chk("done_latency", cyc - e.acc, 9);
                chk("shift_cycles", nsh, W);
                chk("serial_bits", bits, e.w);
                chk("setup_reg", sr, e.w);
                chk("err_at_done", err, e.err);
                chk("ok_at_done", cfg_ok, e.ok);
            end
        end
    end

    // Issue one word; entered and left at a negedge. Leaves the bench in the
    // cycle right after the accept edge.
    task automatic do_load(input logic [W-1:0] w, input logic bad, input logic keep, output int acc);
        int t = 0;
        cfg_data  = w;
        cfg_valid = 1'b1;
        while (!cfg_ready && t < 60) begin
            @(negedge clk);
            t++;
        end
        if (!cfg_ready) begin
            chk("ready_timeout", 0, 1);
            acc = -1;
            cfg_valid = 1'b0;
        end else begin
            rb_force = bad;
            acc = cyc + 1;
            q.push_back('{w: w, err: bad, ok: !bad, acc: acc});
            @(negedge clk);
            if (!keep) cfg_valid = 1'b0;
            chk("accept_clears_err", err, 0);
            chk("accept_clears_ok", cfg_ok, 0);
            chk("accept_busy", {busy, cfg_ready, shift_en}, 3'b101);
        end
    endtask

    task automatic drain();
        int t = 0;
        while (q.size() != 0 && t < 100) begin
            @(negedge clk);
            t++;
        end
        chk("drain", q.size(), 0);
    endtask

    initial begin
        int a, prev, nd;
        logic [W-1:0] b2b [4];
        b2b[0] = 8'h00; b2b[1] = 8'hFF; b2b[2] = 8'h12; b2b[3] = 8'hCD;

        // Reset with a pending request: nothing may be accepted.
        @(posedge clk);
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        cfg_valid = 1'b0;
        @(negedge clk);
        chk("reset_outputs", {cfg_ready, busy, serial, shift_en, done, err, cfg_ok}, 7'b1000000);

        // Single load of 0xAA.
        do_load(8'hAA, 1'b0, 1'b0, a);
        drain();
        chk("single_ok", {err, cfg_ok}, 2'b01);
        chk("single_reg", sr, 8'hAA);

        // Back-to-back with valid held high.
        prev = -1;
        for (int i = 0; i < 4; i++) begin
            do_load(b2b[i], 1'b0, i != 3, a);
            if (prev >= 0) chk("b2b_spacing", a - prev, 10);
            prev = a;
        end
        drain();

        // Mismatch, then a good reload clears the error at its accept edge.
        do_load(8'h12, 1'b1, 1'b0, a);
        drain();
        repeat (3) @(negedge clk);
        chk("mismatch_hold", {err, cfg_ok}, 2'b10);
        do_load(8'h12, 1'b0, 1'b0, a);
        drain();
        chk("reload_ok", {err, cfg_ok}, 2'b01);

        // Requests while busy are ignored.
        do_load(8'hCD, 1'b0, 1'b0, a);
        @(negedge clk);
        cfg_data  = 8'h55;
        cfg_valid = 1'b1;
        @(negedge clk);
        cfg_valid = 1'b0;
        drain();
        repeat (12) @(negedge clk);
        chk("busy_ignore_ok", {err, cfg_ok}, 2'b01);
        chk("busy_ignore_reg", sr, 8'hCD);

        // Reset after three shift cycles.
        do_load(8'hFF, 1'b0, 1'b0, a);
        repeat (2) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        chk("midreset_outputs", {cfg_ready, busy, serial, shift_en, done, err, cfg_ok}, 7'b1000000);
        rst = 1'b0;
        q.delete();
        nd = 0;
        repeat (12) begin
            @(negedge clk);
            if (done) nd++;
        end
        chk("midreset_no_done", nd, 0);
        chk("midreset_no_err", err, 0);
        do_load(8'hFF, 1'b0, 1'b0, a);
        drain();
        chk("after_reset_ok", {err, cfg_ok}, 2'b01);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
